// File: rtl/timer_seq_ctrl.sv
// Interval controller: latches a period/prescale/mode configuration, then sequences
// an up-counter and pulses tick at each terminal count (one-shot or auto-reload).
module timer_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_period,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               cfg_mode,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               tick,
    output logic [WIDTH-1:0]   count,
    output logic [1:0]         dbg_state
);

    // Handshake: a configuration transfers on a rising clk edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is low only while a run is in progress.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               cfg_accept;

    assign cfg_accept = cfg_valid && (state_q != ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            presc_cnt_q <= '0;
            period_q    <= '0;
            presc_q     <= '0;
            mode_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            period_q    <= period_d;
            presc_q     <= presc_d;
            mode_q      <= mode_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        period_d    = period_q;
        presc_d     = presc_q;
        mode_d      = mode_q;
        tick_d      = 1'b0;

        // Config values latched here only take effect from the next edge onward,
        // so a run started on the same edge is governed by the new values.
        if (cfg_accept) begin
            period_d = cfg_period;
            presc_d  = cfg_presc;
            mode_d   = cfg_mode;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    count_d     = '0;
                    presc_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    presc_cnt_d = '0;
                end else if (presc_cnt_q != presc_q) begin
                    presc_cnt_d = presc_cnt_q + 1'b1;
                end else begin
                    presc_cnt_d = '0;
                    if (count_q == period_q) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        state_d = mode_q ? ST_RUN : ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                count_d     = '0;
                presc_cnt_d = '0;
            end
        endcase
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign cfg_ready = (state_q != ST_RUN);
    assign tick      = tick_q;
    assign count     = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl; each scenario task compares the packed
// output vector {busy, done, tick, cfg_ready, count} against hand-derived values.
module tb_timer_seq_ctrl;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 4;
    localparam int OW      = WIDTH + 4;

    logic               clk;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [WIDTH-1:0]   cfg_period;
    logic [PRESC_W-1:0] cfg_presc;
    logic               cfg_mode;
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic               tick;
    logic [WIDTH-1:0]   count;
    logic [1:0]         dbg_state;
    logic [OW-1:0]      obs;

    int n_cmp;
    int n_err;

    timer_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_presc  (cfg_presc),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .tick       (tick),
        .count      (count),
        .dbg_state  (dbg_state)
    );

    assign obs = {busy, done, tick, cfg_ready, count};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] exp_v(input logic b, input logic d, input logic t,
                                            input logic r, input int c);
        logic [WIDTH-1:0] cv;
        cv = c[WIDTH-1:0];
        return {b, d, t, r, cv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_presc  = '0;
        cfg_mode   = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic cfg_and_start(input int p, input int d, input logic m);
        cfg_valid  = 1'b1;
        cfg_period = p[WIDTH-1:0];
        cfg_presc  = d[PRESC_W-1:0];
        cfg_mode   = m;
        start      = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_period = WIDTH'($urandom_range(0, 15));
            cfg_presc  = PRESC_W'($urandom_range(0, 15));
            cfg_mode   = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            stop       = 1'($urandom_range(0, 1));
            step();
            e = exp_v(0, 0, 0, 1, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset_hold_%0d: got %b want %b", i, obs, e);
            end
        end
        drive_idle();
        step();
        rst = 1'b1;
        step();
        e = exp_v(0, 0, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_release: got %b want %b", obs, e);
        end
    endtask

    task automatic test_oneshot();
        logic [OW-1:0] e;
        cfg_and_start(3, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4)       e = exp_v(1, 0, 0, 0, i);
            else if (i == 4) e = exp_v(0, 1, 1, 1, 0);
            else             e = exp_v(0, 1, 0, 1, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL oneshot_e%0d: got %b want %b", i, obs, e);
            end
            if (i < 5) step();
        end
        // restart from DONE with the held configuration
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) e = exp_v(1, 0, 0, 0, i);
            else       e = exp_v(0, 1, 1, 1, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL oneshot_restart_e%0d: got %b want %b", i, obs, e);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_autoreload();
        logic [OW-1:0] e;
        cfg_and_start(2, 1, 1'b1);
        for (int c = 0; c <= 30; c++) begin
            e = exp_v(1, 0, (c % 6 == 0) && (c > 0), 0, (c % 6) / 2);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL autoreload_c%0d: got %b want %b", c, obs, e);
            end
            if (c < 30) step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        e = exp_v(0, 0, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL autoreload_stop: got %b want %b", obs, e);
        end
    endtask

    task automatic test_cfg_handshake();
        logic [OW-1:0] e;
        int exp_c [6] = '{1, 2, 0, 1, 2, 0};
        cfg_and_start(2, 0, 1'b1);
        // offer a conflicting config throughout the run; it must be refused
        cfg_valid  = 1'b1;
        cfg_period = 4'd0;
        cfg_presc  = 4'd3;
        cfg_mode   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            e = exp_v(1, 0, exp_c[i] == 0, 0, exp_c[i]);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL cfg_in_run_%0d: got %b want %b", i, obs, e);
            end
        end
        drive_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        // config and start on the same edge: P=1 terminal at E+2
        cfg_and_start(1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) e = exp_v(1, 0, 0, 0, i);
            else       e = exp_v(0, 1, 1, 1, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL cfg_with_start_e%0d: got %b want %b", i, obs, e);
            end
            if (i < 2) step();
        end
        // config alone and stop in DONE both leave the state in DONE
        cfg_valid  = 1'b1;
        cfg_period = 4'd3;
        stop       = 1'b1;
        step();
        drive_idle();
        e = exp_v(0, 1, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL cfg_in_done: got %b want %b", obs, e);
        end
    endtask

    task automatic test_stop_priority();
        logic [OW-1:0] e;
        cfg_and_start(3, 0, 1'b1);
        step();
        step();
        step();
        e = exp_v(1, 0, 0, 0, 3);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL stop_pre: got %b want %b", obs, e);
        end
        stop  = 1'b1;
        start = 1'b1;
        step();
        drive_idle();
        e = exp_v(0, 0, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL stop_priority: got %b want %b", obs, e);
        end
        step();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL stop_stays_idle: got %b want %b", obs, e);
        end
    endtask

    task automatic test_boundaries();
        logic [OW-1:0] e;
        // P=0, D=2: terminal on every advance, count pinned at 0
        cfg_and_start(0, 2, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            step();
            e = exp_v(1, 0, c % 3 == 0, 0, 0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL period0_c%0d: got %b want %b", c, obs, e);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        // P=15: full range, wrap only through the terminal path
        cfg_and_start(15, 0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c < 16) e = exp_v(1, 0, 0, 0, c);
            else        e = exp_v(0, 1, 1, 1, 0);
            if (c == 15 || c == 16) begin
                n_cmp++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL full_range_c%0d: got %b want %b", c, obs, e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [OW-1:0] e;
        cfg_and_start(5, 0, 1'b0);
        step();
        step();
        e = exp_v(1, 0, 0, 0, 2);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_pre: got %b want %b", obs, e);
        end
        #2;
        rst = 1'b0;
        #1;
        e = exp_v(0, 0, 0, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_reset_immediate: got %b want %b", obs, e);
        end
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_reset_after: got %b want %b", obs, e);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive_idle();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_cfg_handshake();
        test_stop_priority();
        test_boundaries();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
